otn_link_emulator: RTL and testbench
====================================

// Module: otn_link_emulator
// PURPOSE
//   Parametrised channel model between sender OTN TX and receiver OTN RX, with ack return path.
//   Generalises the direct sender->receiver wire: LANES bits per clock, runtime-selectable
//   propagation delay up to MAX_DELAY, and four bit-error injection modes to exercise ARQ/CRC.
//   Single-FPGA demo top instantiates it between sender_inst and receiver_inst.
// PARAMETERS
//   LANES      1       bits carried per clock on forward and ack paths
//   MAX_DELAY  16      depth of delay lines; latency range 1..MAX_DELAY cycles
//   IDLE_LVL   1'b1    line level driven on every lane during reset and flush
//   CNT_W      32      width of statistics counters
// PORTS
//   i_clk            in   1               system clock
//   i_rst            in   1               asynchronous active-high reset
//   i_tx_data        in   LANES           forward stream from sender
//   o_rx_data        out  LANES           delayed/corrupted stream to receiver
//   i_rx_ack         in   LANES           ack stream from receiver
//   o_tx_ack         out  LANES           delayed ack stream to sender (never corrupted)
//   i_delay          in   $clog2(MAX_DELAY)  delay select; latency = i_delay+1 cycles
//   i_corrupt_en     in   1               master enable for error injection
//   i_corrupt_mode   in   2               00 off, 01 single-shot, 10 periodic, 11 random
//   i_inject         in   1               single-shot trigger (rising edge detected)
//   i_err_period     in   16              periodic-mode interval in cycles (0 treated as 1)
//   i_err_thresh     in   8               random-mode flip when lfsr[7:0] < i_err_thresh
//   o_flushing       out  1               high while delay lines refill after i_delay change
//   o_err_cnt        out  CNT_W           bits flipped (stats build only)
//   o_bit_cnt        out  CNT_W           forward bits delivered (stats build only)
// BEHAVIOUR
// - Reset (async): delay lines all IDLE_LVL; o_rx_data/o_tx_ack = {LANES{IDLE_LVL}}; o_flushing=0;
//   counters 0; LFSR = 16'hACE1; FSM RUN; period counter 0; inject edge reg 0.
// - Latency: o_rx_data(t) = i_tx_data(t-(i_delay+1)) ^ mask(t); o_tx_ack same latency, no mask.
//   Output is registered; i_delay=0 gives 1 cycle.
// - i_delay is registered; a change of registered value enters FLUSH: outputs forced IDLE_LVL,
//   o_flushing=1 for exactly new_delay+1 cycles, then RUN. Change during FLUSH restarts count.
// - FSM (per corrupt controller): RUN, FLUSH, ARMED. ARMED entered in mode 01 on i_inject rise
//   with i_corrupt_en=1; next RUN output cycle flips lane 0, return to RUN. Inject in other
//   modes ignored. Reset mid-ARMED discards the pending flip. No flips during FLUSH; an ARMED
//   flip is held until FLUSH exits.
// - Periodic: counter increments each RUN cycle; at count==i_err_period-1 flip lane (k % LANES),
//   k = flip index wrapping at LANES; counter wraps to 0. Counter frozen in FLUSH.
// - Random: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) advances every cycle regardless of mode;
//   flips lane lfsr[15:12] % LANES when condition true. Thresh 0 never flips, 255 ~99.6%.
// - i_corrupt_en=0 or mode 00: mask=0; mode changes take effect next cycle; counter reset to 0
//   on any mode change.
// - At most one bit flipped per cycle in all modes.
// CONFIGURATION
//   LINK_STATS_EN defined: o_err_cnt += popcount(mask) per RUN cycle; o_bit_cnt += LANES per RUN
//   cycle; both saturate at all-ones, cleared only by reset.
//   Not defined: counters not built; o_err_cnt and o_bit_cnt tied to 0.
// STRUCTURE
//   Package otn_link_pkg: mode localparams (MODE_OFF/SINGLE/PERIODIC/RANDOM), FSM state enum,
//   LFSR seed and tap constant.
//   Sub-module link_delay_line (params WIDTH, DEPTH, IDLE_LVL; shift register + tap mux),
//   instantiated twice: forward and ack paths. Corruption FSM, LFSR, stats in top of this block.
// TESTING
// 1 LANES=1, i_delay=3, corrupt off; drive 0,1,1,0 -> o_rx_data shows same pattern 4 cycles later,
//   o_tx_ack mirrors i_rx_ack with 4-cycle latency.
// 2 Mode 01, i_inject pulse at cycle 10, data all 0 -> exactly one 1 on o_rx_data at lane 0;
//   second pulse without new rise does nothing; o_err_cnt=1 (stats build).
// 3 Mode 10, i_err_period=5, LANES=4, data 0 -> flips every 5th cycle on lanes 0,1,2,3,0...
// 4 i_delay 3->7 mid-stream -> o_flushing=1 and outputs IDLE_LVL for 8 cycles, then data with
//   8-cycle latency; no flips during flush.
// 5 Mode 11, thresh 0 for 1000 cycles -> zero flips; thresh 128 -> flip count within 400..600.
// 6 Assert i_rst during ARMED/periodic run -> outputs IDLE_LVL immediately, counters 0, no
//   pending flip after release.

Source files
------------

// File: rtl/otn_link_pkg.sv
// Shared constants for the OTN link emulator: corruption modes, controller states, LFSR setup.
package otn_link_pkg;

    localparam logic [1:0] MODE_OFF      = 2'b00;
    localparam logic [1:0] MODE_SINGLE   = 2'b01;
    localparam logic [1:0] MODE_PERIODIC = 2'b10;
    localparam logic [1:0] MODE_RANDOM   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ARMED = 2'd2
    } link_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/link_delay_line.sv
// Idle-filled shift register with a runtime tap; sel=0 taps the input so the
// registered output stage downstream gives sel+1 cycles of latency.
module link_delay_line #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned DEPTH    = 16,
    parameter logic        IDLE_LVL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(DEPTH)-1:0] sel,
    output logic [WIDTH-1:0]         tap_c
);
    localparam int unsigned SEL_W = $clog2(DEPTH);

    logic [WIDTH-1:0] sr [DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                sr[i] <= {WIDTH{IDLE_LVL}};
            end
        end else begin
            sr[0] <= din;
            for (int unsigned i = 1; i < DEPTH - 1; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    always_comb begin
        tap_c = din;
        if (sel != '0) begin
            tap_c = sr[sel - SEL_W'(1)];
        end
    end

endmodule

// File: rtl/otn_link_emulator.sv
// Channel model between OTN TX and RX: configurable latency, flush on delay change,
// and bit-error injection. Define LINK_STATS_EN to build the error/bit counters.
module otn_link_emulator
    import otn_link_pkg::*;
#(
    parameter int unsigned LANES     = 1,
    parameter int unsigned MAX_DELAY = 16,
    parameter logic        IDLE_LVL  = 1'b1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [LANES-1:0]             i_tx_data,
    output logic [LANES-1:0]             o_rx_data,
    input  logic [LANES-1:0]             i_rx_ack,
    output logic [LANES-1:0]             o_tx_ack,
    input  logic [$clog2(MAX_DELAY)-1:0] i_delay,
    input  logic                         i_corrupt_en,
    input  logic [1:0]                   i_corrupt_mode,
    input  logic                         i_inject,
    input  logic [15:0]                  i_err_period,
    input  logic [7:0]                   i_err_thresh,
    output logic                         o_flushing,
    output logic [CNT_W-1:0]             o_err_cnt,
    output logic [CNT_W-1:0]             o_bit_cnt
);
    localparam int unsigned DLY_W  = $clog2(MAX_DELAY);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANES-1:0] IDLE_WORD = {LANES{IDLE_LVL}};

    link_state_e       state_q, state_d;
    logic              held_q, held_d;
    logic [DLY_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [DLY_W-1:0]  delay_q;
    logic [1:0]        mode_q;
    logic              en_q;
    logic              inject_q;
    logic [15:0]       per_cnt_q;
    logic [LANE_W-1:0] per_idx_q;
    logic [15:0]       lfsr_q;

    logic [LANES-1:0]  fwd_tap_c, ack_tap_c, mask_c;
    logic              delay_chg_c, flush_next_c, active_c;
    logic              single_ok_c, arm_c, per_on_c, per_hit_c, rnd_hit_c, mode_chg_c;
    logic [15:0]       period_m1_c;
    logic [LANE_W-1:0] rnd_lane_c;

    link_delay_line #(.WIDTH(LANES), .DEPTH(MAX_DELAY), .IDLE_LVL(IDLE_LVL)) u_fwd_line (
        .clk   (i_clk),
        .rst   (i_rst),
        .din   (i_tx_data),
        .sel   (delay_q),
        .tap_c (fwd_tap_c)
    );

    link_delay_line #(.WIDTH(LANES), .DEPTH(MAX_DELAY), .IDLE_LVL(IDLE_LVL)) u_ack_line (
        .clk   (i_clk),
        .rst   (i_rst),
        .din   (i_rx_ack),
        .sel   (delay_q),
        .tap_c (ack_tap_c)
    );

    // Error mask for the output word being registered this cycle; at most one bit set.
    always_comb begin
        delay_chg_c  = (i_delay != delay_q);
        flush_next_c = delay_chg_c || ((state_q == ST_FLUSH) && (flush_cnt_q != '0));
        active_c     = !flush_next_c;
        single_ok_c  = en_q && (mode_q == MODE_SINGLE);
        arm_c        = single_ok_c && i_inject && !inject_q;
        per_on_c     = en_q && (mode_q == MODE_PERIODIC);
        mode_chg_c   = (i_corrupt_mode != mode_q);
        period_m1_c  = (i_err_period == '0) ? '0 : i_err_period - 16'd1;
        per_hit_c    = per_on_c && active_c && (per_cnt_q >= period_m1_c);
        rnd_hit_c    = en_q && (mode_q == MODE_RANDOM) && active_c && (lfsr_q[7:0] < i_err_thresh);
        rnd_lane_c   = LANE_W'(32'(lfsr_q[15:12]) % LANES);
        mask_c       = '0;
        if ((state_q == ST_ARMED) && single_ok_c && active_c) begin
            mask_c[0] = 1'b1;
        end else if (per_hit_c) begin
            mask_c[per_idx_q] = 1'b1;
        end else if (rnd_hit_c) begin
            mask_c[rnd_lane_c] = 1'b1;
        end
    end

    // A pending single-shot survives a flush in held_q and re-arms on exit.
    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        flush_cnt_d = flush_cnt_q;
        if (delay_chg_c) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = i_delay;
            held_d      = held_q || (state_q == ST_ARMED) || arm_c;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (arm_c) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_d = (held_q || arm_c) ? ST_ARMED : ST_RUN;
                        held_d  = 1'b0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - DLY_W'(1);
                        held_d      = held_q || arm_c;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            held_q      <= 1'b0;
            flush_cnt_q <= '0;
            delay_q     <= '0;
            mode_q      <= MODE_OFF;
            en_q        <= 1'b0;
            inject_q    <= 1'b0;
            per_cnt_q   <= '0;
            per_idx_q   <= '0;
            lfsr_q      <= LFSR_SEED;
            o_rx_data   <= IDLE_WORD;
            o_tx_ack    <= IDLE_WORD;
            o_flushing  <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            flush_cnt_q <= flush_cnt_d;
            delay_q     <= i_delay;
            mode_q      <= i_corrupt_mode;
            en_q        <= i_corrupt_en;
            inject_q    <= i_inject;
            lfsr_q      <= lfsr_next(lfsr_q);
            o_flushing  <= flush_next_c;
            if (flush_next_c) begin
                o_rx_data <= IDLE_WORD;
                o_tx_ack  <= IDLE_WORD;
            end else begin
                o_rx_data <= fwd_tap_c ^ mask_c;
                o_tx_ack  <= ack_tap_c;
            end
            if (mode_chg_c || !per_on_c) begin
                per_cnt_q <= '0;
                per_idx_q <= '0;
            end else if (per_hit_c) begin
                per_cnt_q <= '0;
                per_idx_q <= (32'(per_idx_q) == LANES - 1) ? '0 : per_idx_q + LANE_W'(1);
            end else if (active_c) begin
                per_cnt_q <= per_cnt_q + 16'd1;
            end
        end
    end

`ifdef LINK_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] err_cnt_q, bit_cnt_q, flips_c;

    assign flips_c = CNT_W'($countones(mask_c));

    // Saturating statistics over delivered (non-flush) cycles
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else if (active_c) begin
            err_cnt_q <= (err_cnt_q > CNT_MAX - flips_c) ? CNT_MAX : err_cnt_q + flips_c;
            bit_cnt_q <= (bit_cnt_q > CNT_MAX - CNT_W'(LANES)) ? CNT_MAX : bit_cnt_q + CNT_W'(LANES);
        end
    end

    assign o_err_cnt = err_cnt_q;
    assign o_bit_cnt = bit_cnt_q;
`else
    assign o_err_cnt = '0;
    assign o_bit_cnt = '0;
`endif

endmodule

// File: tb/tb_otn_link_emulator.sv
// Scoreboard bench for otn_link_emulator (LANES=4): latency, flush, single-shot,
// periodic and random corruption, and reset while a flip is pending.
module tb_otn_link_emulator;
    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 32;
`ifdef LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] rx;
        logic [3:0] ack;
        logic       fl;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   flip_acc = 0;
    bit   count_en = 1'b0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [LANES-1:0] tx, ack_in, rx, ack_out;
    logic [3:0]       dly;
    logic             en, inj, flushing;
    logic [1:0]       mode;
    logic [15:0]      per;
    logic [7:0]       thr;
    logic [CNT_W-1:0] err_cnt, bit_cnt;

    otn_link_emulator #(.LANES(LANES), .MAX_DELAY(16), .IDLE_LVL(1'b1), .CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_tx_data      (tx),
        .o_rx_data      (rx),
        .i_rx_ack       (ack_in),
        .o_tx_ack       (ack_out),
        .i_delay        (dly),
        .i_corrupt_en   (en),
        .i_corrupt_mode (mode),
        .i_inject       (inj),
        .i_err_period   (per),
        .i_err_thresh   (thr),
        .o_flushing     (flushing),
        .o_err_cnt      (err_cnt),
        .o_bit_cnt      (bit_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] r, input logic [3:0] a, input logic f, input string tag);
        exp_t e;
        e.cyc = c; e.rx = r; e.ack = a; e.fl = f; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pat(input int c);
        return 4'(c * 3 + 1);
    endfunction

    function automatic logic [3:0] per_flip(input int i);
        case (i)
            6:  return 4'h1;
            11: return 4'h2;
            16: return 4'h4;
            21: return 4'h8;
            26: return 4'h1;
            default: return 4'h0;
        endcase
    endfunction

    // Monitor: compare every expected entry whose cycle has come due
    always @(negedge clk) begin
        exp_t e;
        if (count_en) flip_acc += $countones(rx);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed cycle %0d now %0d", e.tag, e.cyc, cyc);
            end else begin
                chk({e.tag, "_rx"}, 32'(rx), 32'(e.rx));
                chk({e.tag, "_ack"}, 32'(ack_out), 32'(e.ack));
                chk({e.tag, "_flushing"}, 32'(flushing), 32'(e.fl));
            end
        end
    end

    initial begin
        logic [3:0] t1_tx [8];
        logic [3:0] t1_ack [8];
        int s, b, n, m;
        t1_tx  = '{4'h0, 4'hF, 4'hF, 4'h0, 4'h5, 4'hA, 4'h3, 4'hC};
        t1_ack = '{4'hF, 4'h0, 4'h3, 4'h9, 4'h6, 4'h0, 4'hE, 4'h1};

        tx = '0; ack_in = '0; dly = 4'd3; en = 1'b0; mode = 2'b00; inj = 1'b0;
        per = 16'd5; thr = 8'd0; rst = 1'b1;
        repeat (3) step();
        chk("reset_rx", 32'(rx), 32'hF);
        chk("reset_ack", 32'(ack_out), 32'hF);
        chk("reset_flushing", 32'(flushing), 32'h0);
        chk("reset_err_cnt", err_cnt, 32'h0);
        chk("reset_bit_cnt", bit_cnt, 32'h0);

        // Release: registered delay moves 0 -> 3, so a 4-cycle flush follows
        rst = 1'b0;
        s = cyc;
        for (int i = 1; i <= 4; i++) push(s + i, 4'hF, 4'hF, 1'b1, "release_flush");
        push(s + 5, 4'h0, 4'h0, 1'b0, "release_run");
        repeat (8) step();

        // Latency 4 on both paths, corruption off
        b = cyc;
        for (int i = 0; i < 8; i++) begin
            tx = t1_tx[i];
            ack_in = t1_ack[i];
            push(b + i + 4, t1_tx[i], t1_ack[i], 1'b0, "latency");
            step();
        end
        tx = '0; ack_in = '0;
        repeat (6) step();

        // Single shot: one flip two cycles after the rising edge, held level ignored
        en = 1'b1; mode = 2'b01;
        repeat (3) step();
        n = cyc;
        inj = 1'b1;
        for (int i = 0; i <= 12; i++) push(n + i, (i == 2) ? 4'h1 : 4'h0, 4'h0, 1'b0, "single");
        repeat (5) step();
        inj = 1'b0;
        repeat (8) step();
        chk("single_err_cnt", err_cnt, STATS ? 32'd1 : 32'd0);

        // Periodic, period 5: lanes rotate 0,1,2,3,0
        mode = 2'b10;
        m = cyc;
        for (int i = 2; i <= 28; i++) push(m + i, per_flip(i), 4'h0, 1'b0, "periodic");
        repeat (28) step();

        // Delay 3 -> 7 mid-stream: 8 flush cycles, period counter frozen at 2
        dly = 4'd7;
        for (int c = m + 29; c <= m + 36; c++) push(c, 4'hF, 4'hF, 1'b1, "flush");
        for (int c = m + 37; c <= m + 50; c++) begin
            logic [3:0] f;
            f = (c == m + 39) ? 4'h2 : (c == m + 44) ? 4'h4 : (c == m + 49) ? 4'h8 : 4'h0;
            push(c, pat(c - 8) ^ f, ~pat(c - 8), 1'b0, "post_flush");
        end
        for (int i = 0; i <= 20; i++) begin
            tx = pat(cyc);
            ack_in = ~pat(cyc);
            step();
        end
        tx = '0; ack_in = '0;
        repeat (4) step();

        // Random mode: threshold 0 never flips, 128 flips about half the time
        mode = 2'b11; thr = 8'd0;
        repeat (12) step();
        flip_acc = 0; count_en = 1'b1;
        repeat (1000) step();
        count_en = 1'b0;
        chk("random_thresh0_flips", 32'(flip_acc), 32'd0);
        thr = 8'd128;
        repeat (3) step();
        flip_acc = 0; count_en = 1'b1;
        repeat (1000) step();
        count_en = 1'b0;
        checks++;
        if (flip_acc < 400 || flip_acc > 600) begin
            errors++;
            $display("FAIL random_thresh128_flips got %0d want 400..600", flip_acc);
        end

        // Reset while ARMED: idle immediately, counters cleared, no flip afterwards
        mode = 2'b01; thr = 8'd0;
        repeat (3) step();
        inj = 1'b1;
        step();
        rst = 1'b1; inj = 1'b0;
        #1;
        chk("armed_reset_rx", 32'(rx), 32'hF);
        chk("armed_reset_ack", 32'(ack_out), 32'hF);
        chk("armed_reset_flushing", 32'(flushing), 32'h0);
        chk("armed_reset_err_cnt", err_cnt, 32'h0);
        chk("armed_reset_bit_cnt", bit_cnt, 32'h0);
        repeat (2) step();
        rst = 1'b0;
        s = cyc;
        for (int i = 1; i <= 8; i++) push(s + i, 4'hF, 4'hF, 1'b1, "rerun_flush");
        for (int i = 9; i <= 30; i++) push(s + i, 4'h0, 4'h0, 1'b0, "rerun_clean");
        repeat (34) step();
        chk("rerun_err_cnt", err_cnt, 32'h0);

        for (int i = 0; i < 100 && sb.size() > 0; i++) step();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left %0d entries", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
